// File: rtl/uart_tx_wb_if.sv
// Wishbone classic bundle between the byte FIFO controller (master) and uart_tx_wb (slave).
// Signal names follow the device's point of view (_i into the device, _o out of it).
interface uart_tx_wb_if;
  logic       cyc_i;
  logic       stb_i;
  logic       we_i;
  logic [7:0] dat_i;
  logic [7:0] dat_o;
  logic       ack_o;

  modport master (
    output cyc_i, stb_i, we_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, dat_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/uart_tx_wb.sv
// Wishbone classic UART transmitter, 8N1, LSB first, tx idle high.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1) and report it in read data bit 1.
module uart_tx_wb #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  uart_tx_wb_if.slave wb,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] data);
    even_parity = ^data;
  endfunction
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_ack;
  logic          r_busy;
  logic [7:0]    r_dat_o;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif

  logic          w_req;
  logic          w_wr_req;
  logic          w_rd_req;
  logic          w_bit_end;
  logic [7:0]    w_status;

  // The !ack term keeps a request from being accepted twice while the master drops stb.
  assign w_req     = wb.cyc_i & wb.stb_i & ~r_ack;
  assign w_wr_req  = w_req & wb.we_i;
  assign w_rd_req  = w_req & ~wb.we_i;
  assign w_bit_end = (r_baud == BAUD_LAST);

`ifdef UART_TX_PARITY_EN
  assign w_status  = {6'b000000, r_par, r_busy};
`else
  assign w_status  = {7'b0000000, r_busy};
`endif

  assign tx_o      = r_tx;
  assign busy_o    = r_busy;
  assign wb.ack_o  = r_ack;
  assign wb.dat_o  = r_dat_o;

  // Frame FSM, baud counter, bus acknowledge and read-data register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 1'b1;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_dat_o   <= 8'h00;
`ifdef UART_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;

      // Reads are served in every state and sample busy as it was before this edge.
      if (w_rd_req) begin
        r_ack   <= 1'b1;
        r_dat_o <= w_status;
      end

      if (r_state == S_IDLE) begin
        r_baud <= '0;
      end else if (w_bit_end) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + CW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_wr_req) begin
            r_ack     <= 1'b1;
            r_shift   <= wb.dat_i;
            r_bit_idx <= 3'd0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_START;
`ifdef UART_TX_PARITY_EN
            r_par     <= even_parity(wb.dat_i);
`endif
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_par;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (w_bit_end) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_wb.sv
// Self-checking bench for uart_tx_wb: directed vector table, hand-written corner sequences,
// randomized frames, and an independent line monitor that decodes tx_o against expected frames.
module tb_uart_tx_wb;

  localparam int CPB    = 16;
  localparam int BUDGET = 400;
`ifdef UART_TX_PARITY_EN
  localparam int NB     = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NB     = 10;
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    int         rd_off;
    logic [7:0] rd_exp;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        tx_o;
  logic        busy_o;
  int          cyc_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b1;
  logic        last_par = 1'b0;
  logic [10:0] exp_q[$];

  uart_tx_wb_if wb();

  uart_tx_wb #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wb     (wb),
    .tx_o   (tx_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  // Expected tx sequence, index k = k-th bit on the line: start, 8 data LSB first, [parity], stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f = '0;
    for (int k = 0; k < NB; k++) begin
      if (k == 0)           f[k] = 1'b0;
      else if (k <= 8)      f[k] = (d >> (k - 1)) & 8'h01;
      else if (k == NB - 1) f[k] = 1'b1;
      else                  f[k] = ^d;
    end
    return f;
  endfunction

  function automatic logic [7:0] status_of(input logic busy, input logic par);
    return {6'b000000, par & PAR_EN, busy};
  endfunction

  task automatic wb_drive(input logic req, input logic we, input logic [7:0] d);
    wb.cyc_i = req;
    wb.stb_i = req;
    wb.we_i  = we;
    wb.dat_i = d;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (wb.ack_o !== 1'b1 && n < BUDGET);
  endtask

  task automatic wait_idle(input int t0);
    while (busy_o === 1'b1 && (cyc_cnt - t0) < BUDGET) tick();
    check("frame_len", cyc_cnt - t0, NB * CPB);
    check("idle_tx_high", tx_o, 1'b1);
  endtask

  task automatic do_frame(input logic [7:0] d, input logic [10:0] fr, input int rd_off,
                          input logic [7:0] rd_exp);
    int n;
    int t0;
    exp_q.push_back(fr);
    wb_drive(1'b1, 1'b1, d);
    wait_ack(n);
    check("wr_ack", wb.ack_o, 1'b1);
    check("wr_tx_start_same_cycle", tx_o, 1'b0);
    check("wr_busy", busy_o, 1'b1);
    wb_drive(1'b0, 1'b0, 8'h00);
    t0 = cyc_cnt;
    last_par = ^d;
    tick();
    check("ack_one_cycle", wb.ack_o, 1'b0);
    if (rd_off > 0) begin
      repeat (rd_off) tick();
      wb_drive(1'b1, 1'b0, 8'h00);
      tick();
      check("rd_ack", wb.ack_o, 1'b1);
      check("rd_data_busy", wb.dat_o, rd_exp);
      wb_drive(1'b0, 1'b0, 8'h00);
      tick();
      check("rd_ack_drop", wb.ack_o, 1'b0);
      check("rd_data_hold", wb.dat_o, rd_exp);
    end
    wait_idle(t0);
  endtask

  // Line monitor: finds each start bit and samples every bit in its middle.
  initial begin : monitor
    logic [10:0] got;
    forever begin
      tick();
      if (mon_en && rst_ni === 1'b1 && tx_o === 1'b0) begin
        got = '0;
        repeat (CPB / 2) tick();
        got[0] = tx_o;
        for (int k = 1; k < NB; k++) begin
          repeat (CPB) tick();
          got[k] = tx_o;
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mon_unexpected_frame: got bits 0x%0h with no frame expected", got);
        end else begin
          check("mon_frame", got, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vecs[6];
    logic [10:0] fr;
    logic [7:0]  d;
    logic [7:0]  rexp;
    int          n;
    int          t0;
    int          t1;
    int          bad;
    int          rdo;

    vecs[0] = '{8'h55, 10'h2AA, 0,   8'h00};
    vecs[1] = '{8'hA3, 10'h346, 30,  8'h01};
    vecs[2] = '{8'h00, 10'h200, 0,   8'h00};
    vecs[3] = '{8'hFF, 10'h3FE, 100, 8'h01};
    vecs[4] = '{8'h80, 10'h300, 5,   8'h01};
    vecs[5] = '{8'h01, 10'h202, 0,   8'h00};

    rst_ni = 1'b0;
    wb_drive(1'b0, 1'b0, 8'h00);
    tick();
    tick();
    check("rst_tx", tx_o, 1'b1);
    check("rst_ack", wb.ack_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_dat_o", wb.dat_o, 8'h00);
    #3 rst_ni = 1'b1;

    bad = 0;
    repeat (50) begin
      tick();
      if (tx_o !== 1'b1 || wb.ack_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    for (int i = 0; i < 6; i++) begin
`ifdef UART_TX_PARITY_EN
      fr = {1'b1, ^vecs[i].data, vecs[i].frame[8:0]};
`else
      fr = {1'b0, vecs[i].frame};
`endif
      rexp = vecs[i].rd_exp | {6'b000000, (^vecs[i].data) & PAR_EN, 1'b0};
      tick();
      do_frame(vecs[i].data, fr, vecs[i].rd_off, rexp);
    end

    tick();
    wb_drive(1'b1, 1'b0, 8'h00);
    tick();
    check("idle_rd_ack", wb.ack_o, 1'b1);
    check("idle_rd_data", wb.dat_o, status_of(1'b0, last_par));
    wb_drive(1'b0, 1'b0, 8'h00);
    repeat (5) tick();
    check("idle_rd_hold", wb.dat_o, status_of(1'b0, last_par));

    // Back-to-back: second write arrives mid-frame and must wait for IDLE.
    exp_q.push_back(frame_of(8'h55));
    exp_q.push_back(frame_of(8'hA3));
    wb_drive(1'b1, 1'b1, 8'h55);
    wait_ack(n);
    check("b2b_first_ack", wb.ack_o, 1'b1);
    t0 = cyc_cnt;
    wb_drive(1'b0, 1'b0, 8'h00);
    repeat (4) tick();
    wb_drive(1'b1, 1'b1, 8'hA3);
    wait_ack(n);
    t1 = cyc_cnt;
    check("b2b_second_ack", wb.ack_o, 1'b1);
    check("b2b_spacing", t1 - t0, NB * CPB + 1);
    check("b2b_start_bit", tx_o, 1'b0);
    wb_drive(1'b0, 1'b0, 8'h00);
    last_par = ^(8'hA3);
    wait_idle(t1);

    // Withdrawn write while busy: dropped stb, then cyc, must never be accepted.
    exp_q.push_back(frame_of(8'h5A));
    wb_drive(1'b1, 1'b1, 8'h5A);
    wait_ack(n);
    t0 = cyc_cnt;
    wb_drive(1'b0, 1'b0, 8'h00);
    repeat (10) tick();
    wb_drive(1'b1, 1'b1, 8'h11);
    bad = 0;
    repeat (20) begin
      tick();
      if (wb.ack_o === 1'b1) bad++;
    end
    wb.stb_i = 1'b0;
    repeat (20) begin
      tick();
      if (wb.ack_o === 1'b1) bad++;
    end
    wb.cyc_i = 1'b0;
    wait_idle(t0);
    repeat (30) begin
      tick();
      if (wb.ack_o === 1'b1 || busy_o === 1'b1) bad++;
    end
    check("withdraw_no_accept", bad, 0);

    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 15)) tick();
      rdo = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 120)) : 0;
      do_frame(d, frame_of(d), rdo, status_of(1'b1, ^d));
    end

`ifdef UART_TX_PARITY_EN
    tick();
    do_frame(8'h07, frame_of(8'h07), 0, 8'h00);
    wb_drive(1'b1, 1'b0, 8'h00);
    tick();
    check("par_rd_data", wb.dat_o, 8'h02);
    wb_drive(1'b0, 1'b0, 8'h00);
    tick();
`endif

    // Reset during data bit 4 of 0xFF aborts the frame asynchronously.
    mon_en = 1'b0;
    wb_drive(1'b1, 1'b1, 8'hFF);
    wait_ack(n);
    check("abort_ack", wb.ack_o, 1'b1);
    wb_drive(1'b0, 1'b0, 8'h00);
    repeat (20) tick();
    wb_drive(1'b1, 1'b0, 8'h00);
    tick();
    check("abort_pre_read", wb.dat_o, status_of(1'b1, 1'b0));
    wb_drive(1'b0, 1'b0, 8'h00);
    repeat (64) tick();
    check("abort_busy_before", busy_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("abort_tx_async", tx_o, 1'b1);
    check("abort_busy_async", busy_o, 1'b0);
    check("abort_ack_async", wb.ack_o, 1'b0);
    check("abort_dat_o_async", wb.dat_o, 8'h00);
    repeat (3) tick();
    #3 rst_ni = 1'b1;
    tick();
    check("abort_post_tx", tx_o, 1'b1);
    check("abort_post_busy", busy_o, 1'b0);
    mon_en = 1'b1;
    tick();
    do_frame(8'h00, frame_of(8'h00), 0, 8'h00);

    repeat (20) tick();
    check("all_frames_seen", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
